// File: rtl/multiword_add_sequencer_pkg.sv
// Shared definitions for the multi-word add/subtract sequencer:
// beat width, legal operation lengths and FSM state encodings.
package multiword_add_sequencer_pkg;

  // Width of one beat handled by the shared ripple-carry adder.
  localparam int WORD_W = 16;

  // Legal range for the number of beats per operation.
  localparam int NUM_WORDS_MIN = 2;
  localparam int NUM_WORDS_MAX = 8;

  // Beat index wide enough to count 0..NUM_WORDS_MAX and to address
  // a padded operand word table of 2**BEAT_W entries.
  localparam int BEAT_W = 4;

  // FSM state encodings.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/multiword_add_sequencer_rca.sv
// 16-bit ripple-carry adder, purely combinational.
// Built as a chain of full-adder cells, one per bit.
module ripple_carry_adder_16bit
  import multiword_add_sequencer_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout
);

  logic [WORD_W:0] carry_chain;

  assign carry_chain[0] = cin;

  // One full-adder cell per bit; carry ripples from bit 0 upward.
  generate
    for (genvar gi = 0; gi < WORD_W; gi++) begin : g_fa
      assign sum[gi]           = a[gi] ^ b[gi] ^ carry_chain[gi];
      assign carry_chain[gi+1] = (a[gi] & b[gi]) | (carry_chain[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = carry_chain[WORD_W];

endmodule

// File: rtl/multiword_add_sequencer.sv
// Multi-word add/subtract sequencer. A request is latched in IDLE, then
// one 16-bit beat per cycle is pushed through a single shared ripple-carry
// adder, least significant word first, and the full-width result plus
// carry/overflow flags are held in DONE until the consumer takes them.
module multiword_add_sequencer
  import multiword_add_sequencer_pkg::*;
#(
  parameter int NUM_WORDS = 4  // legal NUM_WORDS_MIN..NUM_WORDS_MAX
)
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        op_sub,
  input  logic [WORD_W*NUM_WORDS-1:0] a_in,
  input  logic [WORD_W*NUM_WORDS-1:0] b_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORD_W*NUM_WORDS-1:0] result,
  output logic                        carry_out,
  output logic                        overflow
);

  localparam int TOTAL_W    = WORD_W * NUM_WORDS;
  localparam int WORD_SLOTS = 2 ** BEAT_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_WORDS - 1);

  logic [1:0]          state_reg;
  logic [BEAT_W-1:0]   beat_reg;
  logic                carry_reg;
  logic                sub_reg;
  logic [TOTAL_W-1:0]  a_reg;
  logic [TOTAL_W-1:0]  b_reg;
  logic [TOTAL_W-1:0]  result_reg;
  logic                carry_out_reg;
  logic                overflow_reg;

  // Operand words addressable by beat index; slots beyond NUM_WORDS read 0.
  logic [WORD_W-1:0]   a_words [WORD_SLOTS];
  logic [WORD_W-1:0]   b_words [WORD_SLOTS];

  logic [WORD_W-1:0]   a_word;
  logic [WORD_W-1:0]   b_eff_word;
  logic [WORD_W-1:0]   sum_word;
  logic                sum_cout;

  generate
    for (genvar gi = 0; gi < WORD_SLOTS; gi++) begin : g_words
      if (gi < NUM_WORDS) begin : g_used
        assign a_words[gi] = a_reg[gi*WORD_W +: WORD_W];
        assign b_words[gi] = b_reg[gi*WORD_W +: WORD_W];
      end else begin : g_pad
        assign a_words[gi] = '0;
        assign b_words[gi] = '0;
      end
    end
  endgenerate

  // Select the current beat; subtraction uses the inverted B word and the
  // carry register was preset to 1 at accept, giving A + ~B + 1.
  always_comb begin
    a_word     = a_words[beat_reg];
    b_eff_word = sub_reg ? ~b_words[beat_reg] : b_words[beat_reg];
  end

  ripple_carry_adder_16bit u_adder (
    .a    (a_word),
    .b    (b_eff_word),
    .cin  (carry_reg),
    .sum  (sum_word),
    .cout (sum_cout)
  );

  // Sequencer FSM and datapath registers. After the last beat there is one
  // settle cycle in CALC (beat index == NUM_WORDS) before DONE, so out_valid
  // rises NUM_WORDS+1 edges after the accept edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      beat_reg      <= '0;
      carry_reg     <= 1'b0;
      sub_reg       <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      result_reg    <= '0;
      carry_out_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            a_reg     <= a_in;
            b_reg     <= b_in;
            sub_reg   <= op_sub;
            beat_reg  <= '0;
            carry_reg <= op_sub;
            state_reg <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (beat_reg <= LAST_BEAT) begin
            result_reg[beat_reg*WORD_W +: WORD_W] <= sum_word;
            carry_reg <= sum_cout;
            beat_reg  <= beat_reg + 1'b1;
            if (beat_reg == LAST_BEAT) begin
              carry_out_reg <= sum_cout;
              overflow_reg  <= (a_word[WORD_W-1] == b_eff_word[WORD_W-1]) &&
                               (sum_word[WORD_W-1] != a_word[WORD_W-1]);
            end
          end else begin
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  assign result    = result_reg;
  assign carry_out = carry_out_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Self-checking bench for multiword_add_sequencer (NUM_WORDS = 4).
// Expected values come from full-width arithmetic in a reference function.
module tb_multiword_add_sequencer;

  localparam int NW = 4;
  localparam int TW = 16 * NW;
  localparam int EXP_LAT = NW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          op_sub;
  logic [TW-1:0] a_in;
  logic [TW-1:0] b_in;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] result;
  logic          carry_out;
  logic          overflow;

  int n_cmp = 0;
  int n_err = 0;

  multiword_add_sequencer #(.NUM_WORDS(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Reference: wrapped unsigned result, carry = no-borrow for subtract,
  // overflow = true signed result does not fit in TW bits.
  function automatic void model(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic sub,
                                output logic [TW-1:0] r, output logic c, output logic o);
    logic [TW:0]   u;
    logic [TW+1:0] s;
    if (sub) begin
      u = {1'b0, a} - {1'b0, b};
      c = (a >= b);
      s = {{2{a[TW-1]}}, a} - {{2{b[TW-1]}}, b};
    end else begin
      u = {1'b0, a} + {1'b0, b};
      c = u[TW];
      s = {{2{a[TW-1]}}, a} + {{2{b[TW-1]}}, b};
    end
    r = u[TW-1:0];
    o = !((s[TW+1] == s[TW]) && (s[TW] == s[TW-1]));
  endfunction

  function automatic logic [TW-1:0] rand_word();
    return {$urandom, $urandom};
  endfunction

  // Present a request while idle and return just after the accept edge.
  task automatic start_op(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic sub);
    @(negedge clk);
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    op_sub   = sub;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
  endtask

  task automatic finish_op();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_handshake: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    n_cmp++;
    if (result !== '0 || carry_out !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: result=%h c=%b v=%b required 0/0/0", result, carry_out, overflow);
    end
  endtask

  task automatic test_directed();
    logic [TW-1:0] ta [4] = '{64'h0000_0000_0000_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                              64'h8000_0000_0000_0000, 64'h0000_0000_0000_0000};
    logic [TW-1:0] tb [4] = '{64'h1, 64'h1, 64'h1, 64'h1};
    logic          ts [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [TW-1:0] tr [4] = '{64'h0000_0000_0001_0000, 64'h0,
                              64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    logic          tc [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic          tv [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int lat;
    for (int i = 0; i < 4; i++) begin
      start_op(ta[i], tb[i], ts[i]);
      wait_done(lat);
      $display("directed %0d: a=%h b=%h sub=%0d -> result=%h c=%0d v=%0d lat=%0d",
               i, ta[i], tb[i], ts[i], result, carry_out, overflow, lat);
      n_cmp++;
      if (lat != EXP_LAT) begin
        n_err++;
        $display("FAIL directed_latency[%0d]: got %0d edges, required %0d", i, lat, EXP_LAT);
      end
      n_cmp++;
      if (result !== tr[i]) begin
        n_err++;
        $display("FAIL directed_result[%0d]: got %h, required %h", i, result, tr[i]);
      end
      n_cmp++;
      if (carry_out !== tc[i] || overflow !== tv[i]) begin
        n_err++;
        $display("FAIL directed_flags[%0d]: got c=%b v=%b, required c=%b v=%b",
                 i, carry_out, overflow, tc[i], tv[i]);
      end
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL directed_in_ready_done[%0d]: got %b, required 0", i, in_ready);
      end
      finish_op();
    end
  endtask

  task automatic test_backpressure();
    logic [TW-1:0] a1, b1, a2, b2, er, er2;
    logic          s1, s2, ec, ev, ec2, ev2;
    int lat;
    a1 = rand_word(); b1 = rand_word(); s1 = 1'($urandom_range(0, 1));
    a2 = rand_word(); b2 = rand_word(); s2 = ~s1;
    model(a1, b1, s1, er, ec, ev);
    model(a2, b2, s2, er2, ec2, ev2);
    start_op(a1, b1, s1);
    wait_done(lat);
    n_cmp++;
    if (lat != EXP_LAT) begin
      n_err++;
      $display("FAIL bp_latency: got %0d edges, required %0d", lat, EXP_LAT);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a_in     = rand_word();
      b_in     = rand_word();
      op_sub   = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== er ||
          carry_out !== ec || overflow !== ev) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: ov=%b ir=%b result=%h c=%b v=%b, required 1/0 %h %b %b",
                 k, out_valid, in_ready, result, carry_out, overflow, er, ec, ev);
      end
    end
    $display("backpressure: a=%h b=%h sub=%0d -> result=%h held 3 cycles", a1, b1, s1, result);
    @(negedge clk);
    a_in      = a2;
    b_in      = b2;
    op_sub    = s2;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_after_handshake: ov=%b ir=%b, required 0/1", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_second_accept: in_ready=%b, required 0", in_ready);
    end
    wait_done(lat);
    $display("backpressure 2nd: a=%h b=%h sub=%0d -> result=%h c=%0d v=%0d lat=%0d",
             a2, b2, s2, result, carry_out, overflow, lat);
    n_cmp++;
    if (lat != EXP_LAT || result !== er2 || carry_out !== ec2 || overflow !== ev2) begin
      n_err++;
      $display("FAIL bp_second_result: lat=%0d result=%h c=%b v=%b, required %0d %h %b %b",
               lat, result, carry_out, overflow, EXP_LAT, er2, ec2, ev2);
    end
    finish_op();
  endtask

  task automatic test_reset_abort();
    int lat;
    start_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || result !== '0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL abort_state: ov=%b result=%h ir=%b, required 0/0/1", out_valid, result, in_ready);
    end
    start_op(64'h2, 64'h3, 1'b0);
    wait_done(lat);
    $display("after abort: a=2 b=3 sub=0 -> result=%h c=%0d v=%0d lat=%0d",
             result, carry_out, overflow, lat);
    n_cmp++;
    if (lat != EXP_LAT || result !== 64'h5 || carry_out !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL abort_followup: lat=%0d result=%h c=%b v=%b, required %0d 5 0 0",
               lat, result, carry_out, overflow, EXP_LAT);
    end
    finish_op();
  endtask

  task automatic test_random();
    logic [TW-1:0] a, b, er;
    logic          s, ec, ev;
    int lat;
    int stall;
    for (int i = 0; i < 24; i++) begin
      a = rand_word();
      b = rand_word();
      case ($urandom_range(0, 5))
        0: a = 64'h8000_0000_0000_0000;
        1: b = 64'h7FFF_FFFF_FFFF_FFFF;
        2: b = a;
        default: ;
      endcase
      s = 1'($urandom_range(0, 1));
      model(a, b, s, er, ec, ev);
      start_op(a, b, s);
      wait_done(lat);
      $display("random %0d: a=%h b=%h sub=%0d -> result=%h c=%0d v=%0d lat=%0d",
               i, a, b, s, result, carry_out, overflow, lat);
      n_cmp++;
      if (lat != EXP_LAT || result !== er || carry_out !== ec || overflow !== ev) begin
        n_err++;
        $display("FAIL random[%0d]: lat=%0d result=%h c=%b v=%b, required %0d %h %b %b",
                 i, lat, result, carry_out, overflow, EXP_LAT, er, ec, ev);
      end
      stall = $urandom_range(0, 2);
      for (int k = 0; k < stall; k++) begin
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || result !== er) begin
          n_err++;
          $display("FAIL random_stall[%0d]: ov=%b result=%h, required 1 %h", i, out_valid, result, er);
        end
      end
      finish_op();
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_sub    = 1'b0;
    a_in      = '0;
    b_in      = '0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
